// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Purpose  : Circular ROB; in-order retire clears busy bits and frees old regs.
//            Optional QU_ROB_PERF_EN adds retire / full-cycle counters.
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
    parameter int ROB_DEPTH         = 16,
    parameter int PHY_RF_ADDR_WIDTH = 6,
    parameter int ROB_ADDR_WIDTH    = $clog2(ROB_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         rob_incr_tail_ptr,
    input  logic                         alloc_rd_valid,
    input  logic [PHY_RF_ADDR_WIDTH-1:0] alloc_phy_rd,
    input  logic [PHY_RF_ADDR_WIDTH-1:0] alloc_old_phy_rd,
    output logic [ROB_ADDR_WIDTH-1:0]    rob_tail_ptr,
    output logic [ROB_ADDR_WIDTH-1:0]    rob_head_ptr,
    output logic                         rob_full,
    output logic                         rob_empty,
    input  logic                         cdb_valid,
    input  logic [ROB_ADDR_WIDTH-1:0]    cdb_rob_addr,
    output logic                         retire_valid,
    output logic                         busy_table_wr_en,
    output logic [PHY_RF_ADDR_WIDTH-1:0] busy_table_wr_addr,
    output logic                         busy_table_wr_data,
    output logic                         free_en,
    output logic [PHY_RF_ADDR_WIDTH-1:0] free_phy_addr
`ifdef QU_ROB_PERF_EN
    ,
    output logic [31:0]                  perf_retired,
    output logic [31:0]                  perf_full_cycles
`endif
);

    localparam int                      c_COUNT_W = ROB_ADDR_WIDTH + 1;
    localparam logic [c_COUNT_W-1:0]    c_DEPTH   = c_COUNT_W'(ROB_DEPTH);
    localparam logic [c_COUNT_W-1:0]    c_CNT_ONE = c_COUNT_W'(1);
    localparam logic [ROB_ADDR_WIDTH-1:0] c_PTR_ONE = ROB_ADDR_WIDTH'(1);

    logic [ROB_ADDR_WIDTH-1:0]    r_head;
    logic [ROB_ADDR_WIDTH-1:0]    r_tail;
    logic [c_COUNT_W-1:0]         r_count;
    logic [ROB_DEPTH-1:0]         r_valid;
    logic [ROB_DEPTH-1:0]         r_done;
    logic [ROB_DEPTH-1:0]         r_rd_valid;
    logic [PHY_RF_ADDR_WIDTH-1:0] r_phy_rd     [ROB_DEPTH];
    logic [PHY_RF_ADDR_WIDTH-1:0] r_old_phy_rd [ROB_DEPTH];

    logic                         r_retire_valid;
    logic                         r_busy_wr_en;
    logic [PHY_RF_ADDR_WIDTH-1:0] r_busy_wr_addr;
    logic                         r_free_en;
    logic [PHY_RF_ADDR_WIDTH-1:0] r_free_addr;

    logic w_alloc;
    logic w_retire;
    logic w_complete;

    assign rob_full     = (r_count == c_DEPTH);
    assign rob_empty    = (r_count == '0);
    assign rob_tail_ptr = r_tail;
    assign rob_head_ptr = r_head;

    assign w_alloc    = rob_incr_tail_ptr && !rob_full;
    assign w_retire   = r_valid[r_head] && r_done[r_head];
    // A completion aimed at the slot being allocated this cycle belongs to a stale uop.
    assign w_complete = cdb_valid && r_valid[cdb_rob_addr]
                        && !(w_alloc && (cdb_rob_addr == r_tail));

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_valid        <= '0;
            r_done         <= '0;
            r_retire_valid <= 1'b0;
            r_busy_wr_en   <= 1'b0;
            r_busy_wr_addr <= '0;
            r_free_en      <= 1'b0;
            r_free_addr    <= '0;
        end else begin
            r_retire_valid <= w_retire;
            r_busy_wr_en   <= w_retire && r_rd_valid[r_head];
            r_free_en      <= w_retire && r_rd_valid[r_head];
            r_busy_wr_addr <= w_retire ? r_phy_rd[r_head]     : '0;
            r_free_addr    <= w_retire ? r_old_phy_rd[r_head] : '0;

            if (w_complete) begin
                r_done[cdb_rob_addr] <= 1'b1;
            end
            if (w_retire) begin
                r_valid[r_head] <= 1'b0;
                r_done[r_head]  <= 1'b0;
                r_head          <= r_head + c_PTR_ONE;
            end
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_tail          <= r_tail + c_PTR_ONE;
            end

            case ({w_alloc, w_retire})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload needs no reset: it is only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_rd_valid[r_tail]   <= alloc_rd_valid;
            r_phy_rd[r_tail]     <= alloc_phy_rd;
            r_old_phy_rd[r_tail] <= alloc_old_phy_rd;
        end
    end

    assign retire_valid       = r_retire_valid;
    assign busy_table_wr_en   = r_busy_wr_en;
    assign busy_table_wr_addr = r_busy_wr_addr;
    assign busy_table_wr_data = 1'b0;
    assign free_en            = r_free_en;
    assign free_phy_addr      = r_free_addr;

`ifdef QU_ROB_PERF_EN
    logic [31:0] r_perf_retired;
    logic [31:0] r_perf_full_cycles;

    // Counters survive flush so they measure the whole run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_retired     <= '0;
            r_perf_full_cycles <= '0;
        end else begin
            if (r_retire_valid) r_perf_retired     <= r_perf_retired + 32'd1;
            if (rob_full)       r_perf_full_cycles <= r_perf_full_cycles + 32'd1;
        end
    end

    assign perf_retired     = r_perf_retired;
    assign perf_full_cycles = r_perf_full_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer
// Purpose  : Directed stimulus with a retire scoreboard for reorder_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

    logic       clk = 1'b0;
    logic       rst, flush, rob_incr_tail_ptr, alloc_rd_valid, cdb_valid;
    logic [5:0] alloc_phy_rd, alloc_old_phy_rd;
    logic [3:0] rob_tail_ptr, rob_head_ptr, cdb_rob_addr;
    logic       rob_full, rob_empty, retire_valid;
    logic       busy_table_wr_en, busy_table_wr_data, free_en;
    logic [5:0] busy_table_wr_addr, free_phy_addr;

    typedef struct packed {
        logic       rdv;
        logic [5:0] phy;
        logic [5:0] old;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pulses = 0;

    reorder_buffer #(.ROB_DEPTH(16), .PHY_RF_ADDR_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .rob_incr_tail_ptr(rob_incr_tail_ptr), .alloc_rd_valid(alloc_rd_valid),
        .alloc_phy_rd(alloc_phy_rd), .alloc_old_phy_rd(alloc_old_phy_rd),
        .rob_tail_ptr(rob_tail_ptr), .rob_head_ptr(rob_head_ptr),
        .rob_full(rob_full), .rob_empty(rob_empty),
        .cdb_valid(cdb_valid), .cdb_rob_addr(cdb_rob_addr),
        .retire_valid(retire_valid), .busy_table_wr_en(busy_table_wr_en),
        .busy_table_wr_addr(busy_table_wr_addr), .busy_table_wr_data(busy_table_wr_data),
        .free_en(free_en), .free_phy_addr(free_phy_addr)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Monitor: every retire strobe must match the oldest outstanding allocation.
    always @(negedge clk) begin
        if (!rst) begin
            if (retire_valid) begin
                exp_t e;
                n_pulses++;
                if (q.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("busy_wr_en", int'(busy_table_wr_en), int'(e.rdv));
                    chk("free_en", int'(free_en), int'(e.rdv));
                    chk("busy_wr_data", int'(busy_table_wr_data), 0);
                    if (e.rdv) begin
                        chk("busy_wr_addr", int'(busy_table_wr_addr), int'(e.phy));
                        chk("free_phy_addr", int'(free_phy_addr), int'(e.old));
                    end
                end
            end else if (busy_table_wr_en || free_en) begin
                chk("stray_strobe", 1, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rob_incr_tail_ptr = 1'b0;
        alloc_rd_valid    = 1'b0;
        alloc_phy_rd      = '0;
        alloc_old_phy_rd  = '0;
        cdb_valid         = 1'b0;
        cdb_rob_addr      = '0;
        flush             = 1'b0;
    endtask

    task automatic set_alloc(input logic rdv, input int phy, input int old);
        rob_incr_tail_ptr = 1'b1;
        alloc_rd_valid    = rdv;
        alloc_phy_rd      = phy[5:0];
        alloc_old_phy_rd  = old[5:0];
        if (!rob_full) q.push_back({rdv, phy[5:0], old[5:0]});
    endtask

    task automatic set_cdb(input int addr);
        cdb_valid    = 1'b1;
        cdb_rob_addr = addr[3:0];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        q.delete();
    endtask

    initial begin
        int snap;
        idle();
        do_reset();

        chk("reset_empty", int'(rob_empty), 1);
        chk("reset_full", int'(rob_full), 0);
        chk("reset_tail", int'(rob_tail_ptr), 0);
        chk("reset_head", int'(rob_head_ptr), 0);
        chk("reset_retire", int'(retire_valid), 0);
        chk("reset_busy_en", int'(busy_table_wr_en), 0);
        chk("reset_free_en", int'(free_en), 0);

        // In-order retire despite out-of-order completion
        for (int i = 0; i < 3; i++) begin
            set_alloc(1'b1, 40 + i, 5 + i);
            step();
            idle();
        end
        chk("alloc3_tail", int'(rob_tail_ptr), 3);
        chk("alloc3_empty", int'(rob_empty), 0);
        set_cdb(2); step(); idle();
        set_cdb(0); step(); idle();
        chk("ooo_no_retire_yet", int'(retire_valid), 0);
        set_cdb(1); step(); idle();
        chk("retire0_valid", int'(retire_valid), 1);
        chk("retire0_head", int'(rob_head_ptr), 1);
        step();
        chk("retire1_valid", int'(retire_valid), 1);
        step();
        chk("retire2_valid", int'(retire_valid), 1);
        chk("retire2_head", int'(rob_head_ptr), 3);
        step();
        chk("drained_retire", int'(retire_valid), 0);
        chk("drained_empty", int'(rob_empty), 1);

        // Fill to full, reject a 17th allocation
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_alloc(1'b1, 10 + i, 20 + i);
            step();
            idle();
        end
        chk("full_flag", int'(rob_full), 1);
        chk("full_tail", int'(rob_tail_ptr), 0);
        set_alloc(1'b1, 60, 61);
        step();
        idle();
        chk("full_ignored_tail", int'(rob_tail_ptr), 0);
        chk("full_still_full", int'(rob_full), 1);
        set_cdb(0); step(); idle();
        chk("full_no_retire_yet", int'(retire_valid), 0);
        step();
        chk("full_retire_valid", int'(retire_valid), 1);
        chk("full_cleared", int'(rob_full), 0);

        // Wrap: overlapping allocate/complete/retire for 20 entries
        do_reset();
        snap = n_pulses;
        for (int i = 0; i < 20; i++) begin
            set_alloc(1'b1, 30 + i, i);
            if (i > 0) set_cdb((i - 1) % 16);
            step();
            idle();
        end
        set_cdb(3); step(); idle();
        step();
        step();
        chk("wrap_tail", int'(rob_tail_ptr), 4);
        chk("wrap_head", int'(rob_head_ptr), 4);
        chk("wrap_pulses", n_pulses - snap, 20);
        chk("wrap_empty", int'(rob_empty), 1);

        // rd_valid=0 entry; a same-cycle completion on the new slot is dropped
        set_alloc(1'b0, 9, 9);
        set_cdb(4);
        step(); idle();
        step(); step();
        chk("alloc_wins_no_retire", int'(retire_valid), 0);
        set_cdb(4); step(); idle();
        step();
        chk("nord_retire_valid", int'(retire_valid), 1);
        chk("nord_head", int'(rob_head_ptr), 5);

        // Flush with 5 live entries and a done head
        for (int i = 0; i < 5; i++) begin
            set_alloc(1'b1, 1 + i, 11 + i);
            step();
            idle();
        end
        set_cdb(5); step(); idle();
        flush = 1'b1;
        step();
        idle();
        q.delete();
        chk("flush_empty", int'(rob_empty), 1);
        chk("flush_head", int'(rob_head_ptr), 0);
        chk("flush_tail", int'(rob_tail_ptr), 0);
        chk("flush_no_retire", int'(retire_valid), 0);
        set_alloc(1'b1, 50, 51);
        step(); idle();
        chk("post_flush_tail", int'(rob_tail_ptr), 1);
        set_cdb(0); step(); idle();
        step();
        chk("post_flush_retire", int'(retire_valid), 1);
        step();

        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
